bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single port of a 1104-word, 32-bit matrix BRAM.
- Requester 0 is the host loader/unloader; requester 1 is the multiplier compute core.
- Registers every BRAM-side signal, tracks the 1-cycle BRAM read latency and routes each read result back to its issuer.
- Sits between both masters and the BRAM's BRAM_* port.

Parameters:
- BRAM_ADDR_WIDTH, 13, byte-address width; word index = addr[BRAM_ADDR_WIDTH-1:2]
- BRAM_DEPTH, 1104, number of 32-bit words in the BRAM

Ports:
- BRAM_CLK  in  1  single clock for arbiter and BRAM
- BRAM_RSTN  in  1  asynchronous active-low reset
- REQ0_VALID / REQ1_VALID  in  1  access request
- REQ0_READY / REQ1_READY  out  1  grant; transfer occurs when VALID&READY
- REQ0_ADDR / REQ1_ADDR  in  BRAM_ADDR_WIDTH  byte address
- REQ0_WRDATA / REQ1_WRDATA  in  32  write data
- REQ0_WE / REQ1_WE  in  4  byte write enables; 0000 = read
- REQ0_RDVALID / REQ1_RDVALID  out  1  read-data strobe, one cycle
- REQ0_RDDATA / REQ1_RDDATA  out  32  read data, meaningful only with RDVALID
- REQ0_ERR / REQ1_ERR  out  1  address-range error pulse (see Optional Feature)
- BRAM_ADDR  out  BRAM_ADDR_WIDTH  to BRAM, registered
- BRAM_WRDATA  out  32  to BRAM, registered
- BRAM_WE  out  4  to BRAM, registered
- BRAM_EN  out  1  to BRAM, registered
- BRAM_RST  out  1  to BRAM synchronous output-register reset
- BRAM_RDDATA  in  32  from BRAM

Behaviour:
- Reset (BRAM_RSTN=0, async):
  - BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_WRDATA, all RDVALID and ERR = 0.
  - BRAM_RST = 1; it deasserts on the first BRAM_CLK edge after BRAM_RSTN rises.
  - Round-robin pointer is set so requester 0 has priority.
- Arbitration (combinational, at most one grant per cycle):
  - READY may depend on VALID; VALID must not depend on READY.
  - READY is 0 for every requester while BRAM_RST=1.
  - Only one requester valid: it gets READY.
  - Both requesters valid: the one not granted last gets READY.
  - Pointer updates only on an accepted transfer; idle cycles leave it unchanged.
- Issue (cycle T = accept cycle, no stall, full rate every cycle):
  - At the T edge, register BRAM_ADDR, BRAM_WRDATA, BRAM_WE and BRAM_EN=1.
  - In cycle T+1, BRAM_EN=1 with the captured values.
  - A cycle with no accept gives BRAM_EN=0 and BRAM_WE=0 in the next cycle.
- Read response:
  - Tag pipeline {is_read, id} tracks each access for 2 stages.
  - REQn_RDVALID=1 in cycle T+2 for the issuer only.
  - REQn_RDDATA = BRAM_RDDATA, muxed to both outputs.
  - Writes (any WE bit set) produce no RDVALID.
  - Back-to-back reads from alternating requesters give alternating RDVALIDs at full rate.
- Read-after-write on the same address:
  - Accept order is preserved.
  - A read accepted after a write returns the written data; the BRAM is write-first across cycles.
- Reset mid-operation: in-flight tags are cleared; no RDVALID or ERR is emitted for accesses accepted before reset.

Optional Feature:
- Macro: BRAM_ARB_ADDR_CHECK_EN.
- Defined:
  - An accepted request whose word index is >= BRAM_DEPTH is still handshaken.
  - It is not issued: BRAM_EN=0 in T+1.
  - REQn_ERR pulses in T+2.
  - Reads in that case also give RDVALID=1 in T+2 with RDDATA forced to 0.
  - The round-robin pointer still advances.
- Undefined:
  - No check; all requests are issued and ERR outputs are tied 0.
  - Out-of-range index behaviour is whatever the BRAM does.

Test Plan:
- Reset then single read: REQ0 read addr 0x0010 (word 4 preloaded 0xDEADBEEF), accepted T -> BRAM_EN=1, BRAM_ADDR=0x0010 at T+1; REQ0_RDVALID=1, RDDATA=0xDEADBEEF at T+2; REQ1_RDVALID stays 0.
- Contention: both valid continuously for 6 cycles (R0 reads word 0..2, R1 reads word 10..12) -> grants R0,R1,R0,R1,R0,R1; RDVALID alternates correctly with matching data, no bubbles.
- Byte write then read: REQ1 write addr 0x0020, data 0x11223344, WE=0100, word 8 initially 0xAABBCCDD -> next REQ1 read of 0x0020 returns 0xAA22CCDD.
- Write/read ordering: R0 writes 0x55 to word 3 at T, R1 reads word 3 at T+1 -> R1 RDDATA=0x00000055 at T+3.
- Reset mid-flight: R0 read accepted at T, BRAM_RSTN low during T+1 -> no RDVALID at T+2; BRAM_RST=1 until the first edge after release; next grant goes to R0.
- With BRAM_ARB_ADDR_CHECK_EN: R1 read addr 0x1140 (word 1104) -> BRAM_EN=0 at T+1; REQ1_ERR=1, RDVALID=1, RDDATA=0 at T+2.
- Without BRAM_ARB_ADDR_CHECK_EN: the same request issues and ERR stays 0.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: one requester's access channel into the shared BRAM port.
interface bram_port_arbiter_if #(
   parameter int ADDR_WIDTH = 13
);
   logic                  valid;
   logic                  ready;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           wrdata;
   logic [3:0]            we;
   logic                  rdvalid;
   logic [31:0]           rddata;
   logic                  err;
   modport master (output valid, addr, wrdata, we, input ready, rdvalid, rddata, err);
   modport slave  (input valid, addr, wrdata, we, output ready, rdvalid, rddata, err);
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one registered BRAM port between two requesters.
// Define BRAM_ARB_ADDR_CHECK_EN to reject word indices >= BRAM_DEPTH with an ERR pulse instead of issuing them.
module bram_port_arbiter #(
   parameter int BRAM_ADDR_WIDTH = 13,
   parameter int BRAM_DEPTH      = 1104
) (
   input  logic                       BRAM_CLK,
   input  logic                       BRAM_RSTN,
   bram_port_arbiter_if.slave         req0,
   bram_port_arbiter_if.slave         req1,
   output logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
   output logic [31:0]                BRAM_WRDATA,
   output logic [3:0]                 BRAM_WE,
   output logic                       BRAM_EN,
   output logic                       BRAM_RST,
   input  logic [31:0]                BRAM_RDDATA
);
`ifdef BRAM_ARB_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic                       last;
   logic                       gnt0;
   logic                       gnt1;
   logic                       acc;
   logic                       rd;
   logic                       oor;
   logic                       issue;
   logic [BRAM_ADDR_WIDTH-1:0] addr;
   logic [31:0]                wrdata;
   logic [3:0]                 we;
   logic                       t1_rd;
   logic                       t1_err;
   logic                       t1_id;
   logic                       err_q;
   // last holds the id granted most recently; under contention the other side wins
   assign gnt0   = !BRAM_RST && req0.valid && (!req1.valid || last);
   assign gnt1   = !BRAM_RST && req1.valid && (!req0.valid || !last);
   assign acc    = gnt0 || gnt1;
   assign addr   = gnt1 ? req1.addr : req0.addr;
   assign wrdata = gnt1 ? req1.wrdata : req0.wrdata;
   assign we     = gnt1 ? req1.we : req0.we;
   assign rd     = (we == 4'b0000);
   assign oor    = CHK && (int'(addr[BRAM_ADDR_WIDTH-1:2]) >= BRAM_DEPTH);
   assign issue  = acc && !oor;
   assign req0.ready  = gnt0;
   assign req1.ready  = gnt1;
   assign req0.rddata = err_q ? 32'h0 : BRAM_RDDATA;
   assign req1.rddata = err_q ? 32'h0 : BRAM_RDDATA;
   always_ff @(posedge BRAM_CLK or negedge BRAM_RSTN) begin
      if (!BRAM_RSTN) begin
         BRAM_RST     <= 1'b1;
         BRAM_EN      <= 1'b0;
         BRAM_WE      <= 4'b0;
         BRAM_ADDR    <= '0;
         BRAM_WRDATA  <= '0;
         last         <= 1'b1;
         t1_rd        <= 1'b0;
         t1_err       <= 1'b0;
         t1_id        <= 1'b0;
         err_q        <= 1'b0;
         req0.rdvalid <= 1'b0;
         req1.rdvalid <= 1'b0;
         req0.err     <= 1'b0;
         req1.err     <= 1'b0;
      end else begin
         BRAM_RST     <= 1'b0;
         BRAM_EN      <= issue;
         BRAM_WE      <= issue ? we : 4'b0;
         if (acc) begin
            BRAM_ADDR   <= addr;
            BRAM_WRDATA <= wrdata;
            last        <= gnt1;
         end
         t1_rd        <= acc && rd;
         t1_err       <= acc && oor;
         t1_id        <= gnt1;
         err_q        <= t1_err;
         req0.rdvalid <= t1_rd && !t1_id;
         req1.rdvalid <= t1_rd && t1_id;
         req0.err     <= t1_err && !t1_id;
         req1.err     <= t1_err && t1_id;
      end
   end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed stimulus against a transaction-level arbiter/BRAM model.
module tb_bram_port_arbiter;
`ifdef BRAM_ARB_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [12:0] bram_addr;
   logic [31:0] bram_wrdata;
   logic [31:0] bram_rddata;
   logic [3:0]  bram_we;
   logic        bram_en;
   logic        bram_rst;
   int          n_chk = 0;
   int          n_pass = 0;
   bram_port_arbiter_if #(.ADDR_WIDTH(13)) r0 ();
   bram_port_arbiter_if #(.ADDR_WIDTH(13)) r1 ();
   bram_port_arbiter dut (
      .BRAM_CLK(clk), .BRAM_RSTN(rst_n), .req0(r0), .req1(r1),
      .BRAM_ADDR(bram_addr), .BRAM_WRDATA(bram_wrdata), .BRAM_WE(bram_we),
      .BRAM_EN(bram_en), .BRAM_RST(bram_rst), .BRAM_RDDATA(bram_rddata)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] init_val(int i);
      return i == 4 ? 32'hDEADBEEF : i == 8 ? 32'hAABBCCDD : 32'h1000_0000 + 32'(i);
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask
   // BRAM: 1-cycle registered read, synchronous output reset
   logic [31:0] mem [0:2047];
   logic        loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 2048; i++) mem[i] <= init_val(i);
         loaded <= 1'b1;
      end else if (bram_en) begin
         for (int b = 0; b < 4; b++) if (bram_we[b]) mem[bram_addr[12:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
      end
      if (bram_rst) bram_rddata <= 32'h0;
      else if (bram_en && bram_we == 4'b0) bram_rddata <= mem[bram_addr[12:2]];
   end
   // model: grants by rule, accesses applied in accept order, results scheduled two cycles later
   typedef struct packed {logic en; logic [12:0] addr; logic [3:0] we; logic [31:0] wd;} iss_t;
   typedef struct packed {logic [1:0] rv; logic [1:0] er; logic [31:0] data;} rsp_t;
   logic [31:0] ref_mem [0:2047];
   iss_t iss = '0;
   rsp_t r_cur = '0;
   rsp_t r_nxt = '0;
   logic m_rst = 1'b1;
   logic m_last = 1'b1;
   always @(negedge clk) begin
      logic        g0, g1, id, oor;
      logic [12:0] a;
      logic [3:0]  w;
      logic [31:0] d;
      int          idx;
      if (!rst_n) begin
         chk("rst_en", bram_en, 0);
         chk("rst_we", bram_we, 0);
         chk("rst_bram_rst", bram_rst, 1);
         chk("rst_ready", {r0.ready, r1.ready}, 0);
         chk("rst_rdvalid", {r0.rdvalid, r1.rdvalid}, 0);
         chk("rst_err", {r0.err, r1.err}, 0);
         m_rst = 1'b1;
         m_last = 1'b1;
         iss = '0;
         r_cur = '0;
         r_nxt = '0;
      end else begin
         if (m_rst) begin
            g0 = 1'b0;
            g1 = 1'b0;
         end else if (r0.valid && r1.valid) begin
            g1 = (m_last == 1'b0);
            g0 = !g1;
         end else begin
            g0 = r0.valid;
            g1 = r1.valid;
         end
         chk("ready0", r0.ready, g0);
         chk("ready1", r1.ready, g1);
         chk("bram_rst", bram_rst, m_rst);
         chk("bram_en", bram_en, iss.en);
         chk("bram_we", bram_we, iss.we);
         if (iss.en) begin
            chk("bram_addr", bram_addr, iss.addr);
            if (iss.we != 0) chk("bram_wrdata", bram_wrdata, iss.wd);
         end
         chk("rdvalid0", r0.rdvalid, r_cur.rv[0]);
         chk("rdvalid1", r1.rdvalid, r_cur.rv[1]);
         chk("err0", r0.err, r_cur.er[0]);
         chk("err1", r1.err, r_cur.er[1]);
         if (r_cur.rv[0]) chk("rddata0", r0.rddata, r_cur.data);
         if (r_cur.rv[1]) chk("rddata1", r1.rddata, r_cur.data);
         r_cur = r_nxt;
         r_nxt = '0;
         iss = '0;
         if (g0 || g1) begin
            id = g1;
            a = id ? r1.addr : r0.addr;
            w = id ? r1.we : r0.we;
            d = id ? r1.wrdata : r0.wrdata;
            idx = int'(a[12:2]);
            oor = CHK && idx >= 1104;
            m_last = id;
            if (!oor) iss = '{1'b1, a, w, d};
            if (w != 0) begin
               if (!oor) for (int b = 0; b < 4; b++) if (w[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end else begin
               r_nxt.rv[id] = 1'b1;
               r_nxt.data = oor ? 32'h0 : ref_mem[idx];
            end
            if (oor) r_nxt.er[id] = 1'b1;
         end
         m_rst = 1'b0;
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drv0(input logic v, input logic [12:0] a, input logic [3:0] w, input logic [31:0] d);
      r0.valid = v;
      r0.addr = a;
      r0.we = w;
      r0.wrdata = d;
   endtask
   task automatic drv1(input logic v, input logic [12:0] a, input logic [3:0] w, input logic [31:0] d);
      r1.valid = v;
      r1.addr = a;
      r1.we = w;
      r1.wrdata = d;
   endtask
   initial begin
      int i0, i1;
      for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
      drv0(0, 0, 0, 0);
      drv1(0, 0, 0, 0);
      repeat (3) step();
      chk("lit_reset_bram_rst", bram_rst, 1);
      chk("lit_reset_en", bram_en, 0);
      // release reset with a read already pending: no grant until BRAM_RST drops
      step();
      rst_n = 1'b1;
      drv0(1, 13'h0010, 4'b0, 0);
      #1 chk("lit_ready_during_bram_rst", r0.ready, 0);
      step();
      #1 chk("lit_single_read_ready", r0.ready, 1);
      step();
      drv0(0, 0, 0, 0);
      #1 chk("lit_issue_en", bram_en, 1);
      chk("lit_issue_addr", bram_addr, 13'h0010);
      step();
      #1 chk("lit_rdvalid0", r0.rdvalid, 1);
      chk("lit_rddata0", r0.rddata, 32'hDEADBEEF);
      chk("lit_rdvalid1_quiet", r1.rdvalid, 0);
      // byte write then read back
      step();
      drv1(1, 13'h0020, 4'b0100, 32'h11223344);
      #1 chk("lit_bw_ready", r1.ready, 1);
      step();
      drv1(1, 13'h0020, 4'b0000, 0);
      step();
      drv1(0, 0, 0, 0);
      step();
      #1 chk("lit_bw_rdvalid", r1.rdvalid, 1);
      chk("lit_bw_rddata", r1.rddata, 32'hAA22CCDD);
      // contention, last grant was requester 1
      i0 = 0;
      i1 = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         drv0(1, 13'(i0 * 4), 4'b0, 0);
         drv1(1, 13'((10 + i1) * 4), 4'b0, 0);
         #1 chk("lit_rr_grant", {r0.ready, r1.ready}, (k % 2 == 0) ? 32'd2 : 32'd1);
         if (k % 2 == 0) i0++;
         else i1++;
      end
      step();
      drv0(0, 0, 0, 0);
      drv1(0, 0, 0, 0);
      repeat (2) step();
      // write then read of the same word by the other requester
      step();
      drv0(1, 13'h000C, 4'b1111, 32'h00000055);
      step();
      drv0(0, 0, 0, 0);
      drv1(1, 13'h000C, 4'b0000, 0);
      step();
      drv1(0, 0, 0, 0);
      step();
      #1 chk("lit_raw_rdvalid", r1.rdvalid, 1);
      chk("lit_raw_rddata", r1.rddata, 32'h00000055);
      // reset with a read in flight
      step();
      drv0(1, 13'h0000, 4'b0, 0);
      step();
      drv0(0, 0, 0, 0);
      rst_n = 1'b0;
      #1 chk("lit_midrst_en", bram_en, 0);
      step();
      rst_n = 1'b1;
      drv0(1, 13'h0004, 4'b0, 0);
      drv1(1, 13'h0030, 4'b0, 0);
      #1 chk("lit_midrst_no_rdvalid", r0.rdvalid, 0);
      chk("lit_midrst_bram_rst", bram_rst, 1);
      chk("lit_midrst_no_ready", {r0.ready, r1.ready}, 0);
      step();
      #1 chk("lit_post_rst_bram_rst", bram_rst, 0);
      chk("lit_post_rst_grant", {r0.ready, r1.ready}, 2);
      step();
      drv0(0, 0, 0, 0);
      step();
      drv1(0, 0, 0, 0);
      repeat (2) step();
      // word 1104 is one past the end of the matrix
      step();
      drv1(1, 13'h1140, 4'b0, 0);
      step();
      drv1(0, 0, 0, 0);
      #1 chk("lit_oor_en", bram_en, CHK ? 0 : 1);
      step();
      #1 chk("lit_oor_err1", r1.err, CHK ? 1 : 0);
      chk("lit_oor_err0", r0.err, 0);
      chk("lit_oor_rdvalid", r1.rdvalid, 1);
      chk("lit_oor_rddata", r1.rddata, CHK ? 32'h0 : 32'h10000450);
      step();
      drv0(1, 13'h0008, 4'b0, 0);
      drv1(1, 13'h000C, 4'b0, 0);
      #1 chk("lit_oor_ptr_advanced", {r0.ready, r1.ready}, 2);
      step();
      drv0(0, 0, 0, 0);
      step();
      drv1(0, 0, 0, 0);
      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
